// File: rtl/cpu_nios_div_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cpu_nios_div_pkg : shared constants, FSM states and helpers for the divider
// Revision 1.0
// ---------------------------------------------------------------------------
package cpu_nios_div_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_ITERS = 32;
  localparam int DIV_CNT_W = $clog2(DIV_ITERS);

  localparam logic [DIV_WIDTH-1:0] DIV_BY_ZERO_QUOTIENT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } div_state_e;

  // Magnitude of a two's complement value; passthrough when not signed.
  function automatic logic [DIV_WIDTH-1:0] div_abs(input logic [DIV_WIDTH-1:0] v,
                                                   input logic                 is_signed);
    return (is_signed && v[DIV_WIDTH-1]) ? -v : v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_nios_div_step.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cpu_nios_div_step : one combinational radix-2 restoring division step
// Revision 1.0
// ---------------------------------------------------------------------------
module cpu_nios_div_step
  import cpu_nios_div_pkg::*;
(
  input  logic [DIV_WIDTH-1:0] rem_i,
  input  logic                 dvd_msb_i,
  input  logic [DIV_WIDTH-1:0] dvs_i,
  output logic [DIV_WIDTH-1:0] rem_o,
  output logic                 q_bit_o
);

  logic [DIV_WIDTH:0] shifted;
  logic [DIV_WIDTH:0] trial;

  // The shifted remainder keeps rem_i[31]: divisors above 2^31 leave a
  // partial remainder with its top bit set, which must not be dropped.
  always_comb begin
    shifted = {rem_i, dvd_msb_i};
    trial   = shifted - {1'b0, dvs_i};
    q_bit_o = ~trial[DIV_WIDTH];
    rem_o   = q_bit_o ? trial[DIV_WIDTH-1:0] : shifted[DIV_WIDTH-1:0];
  end

endmodule
`default_nettype wire

// File: rtl/cpu_nios_cpu_div_cell.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cpu_nios_cpu_div_cell : iterative 32-bit div/divu with start/busy/done.
// Optional macro CPU_NIOS_DIV_ZERO_FASTPATH_EN skips CALC on divide by zero.
// Revision 1.0
// ---------------------------------------------------------------------------
module cpu_nios_cpu_div_cell
  import cpu_nios_div_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 A_div_start,
  input  logic                 A_div_signed,
  input  logic [DIV_WIDTH-1:0] A_div_src1,
  input  logic [DIV_WIDTH-1:0] A_div_src2,
  output logic                 A_div_busy,
  output logic                 A_div_done,
  output logic [DIV_WIDTH-1:0] A_div_quotient,
  output logic [DIV_WIDTH-1:0] A_div_remainder
);

  localparam logic [DIV_CNT_W-1:0] LAST_ITER = DIV_CNT_W'(DIV_ITERS - 1);

  div_state_e           state_q, state_d;
  logic [DIV_CNT_W-1:0] cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0] rem_q, rem_d;
  logic [DIV_WIDTH-1:0] dvd_q, dvd_d;
  logic [DIV_WIDTH-1:0] dvs_q, dvs_d;
  logic [DIV_WIDTH-1:0] src1_q, src1_d;
  logic                 neg_quot_q, neg_quot_d;
  logic                 neg_rem_q, neg_rem_d;
  logic                 dz_q, dz_d;
  logic [DIV_WIDTH-1:0] quot_q, quot_d;
  logic [DIV_WIDTH-1:0] remd_q, remd_d;
  logic                 done_q, done_d;

  logic [DIV_WIDTH-1:0] step_rem;
  logic                 step_qbit;

  cpu_nios_div_step u_step (
    .rem_i     (rem_q),
    .dvd_msb_i (dvd_q[DIV_WIDTH-1]),
    .dvs_i     (dvs_q),
    .rem_o     (step_rem),
    .q_bit_o   (step_qbit)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    dvd_d      = dvd_q;
    dvs_d      = dvs_q;
    src1_d     = src1_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    dz_d       = dz_q;
    quot_d     = quot_q;
    remd_d     = remd_q;
    done_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (A_div_start) begin
          neg_quot_d = A_div_signed & (A_div_src1[DIV_WIDTH-1] ^ A_div_src2[DIV_WIDTH-1]);
          neg_rem_d  = A_div_signed & A_div_src1[DIV_WIDTH-1];
          dvd_d      = div_abs(A_div_src1, A_div_signed);
          dvs_d      = div_abs(A_div_src2, A_div_signed);
          src1_d     = A_div_src1;
          rem_d      = '0;
          cnt_d      = '0;
          dz_d       = (A_div_src2 == '0);
`ifdef CPU_NIOS_DIV_ZERO_FASTPATH_EN
          state_d    = (A_div_src2 == '0) ? ST_FIX : ST_CALC;
`else
          state_d    = ST_CALC;
`endif
        end
      end

      ST_CALC: begin
        rem_d = step_rem;
        dvd_d = {dvd_q[DIV_WIDTH-2:0], step_qbit};
        cnt_d = cnt_q + DIV_CNT_W'(1);
        if (cnt_q == LAST_ITER) begin
          state_d = ST_FIX;
        end
      end

      ST_FIX: begin
        // Signed overflow needs no special case: -(0x80000000) wraps to itself.
        if (dz_q) begin
          quot_d = DIV_BY_ZERO_QUOTIENT;
          remd_d = src1_q;
        end else begin
          quot_d = neg_quot_q ? -dvd_q : dvd_q;
          remd_d = neg_rem_q  ? -rem_q : rem_q;
        end
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      rem_q      <= '0;
      dvd_q      <= '0;
      dvs_q      <= '0;
      src1_q     <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      dz_q       <= 1'b0;
      quot_q     <= '0;
      remd_q     <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      dvd_q      <= dvd_d;
      dvs_q      <= dvs_d;
      src1_q     <= src1_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      dz_q       <= dz_d;
      quot_q     <= quot_d;
      remd_q     <= remd_d;
      done_q     <= done_d;
    end
  end

  assign A_div_busy      = (state_q != ST_IDLE);
  assign A_div_done      = done_q;
  assign A_div_quotient  = quot_q;
  assign A_div_remainder = remd_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_nios_cpu_div_cell.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_cpu_nios_cpu_div_cell : scoreboard bench for the iterative divider
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_cpu_nios_cpu_div_cell;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    int          done_cyc;
  } exp_t;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic        sgn;
  logic [31:0] src1;
  logic [31:0] src2;
  logic        busy;
  logic        done;
  logic [31:0] quot;
  logic [31:0] remd;

  int   cyc;
  int   checks;
  int   failures;
  int   done_seen;
  exp_t sb[$];

  cpu_nios_cpu_div_cell dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .A_div_start     (start),
    .A_div_signed    (sgn),
    .A_div_src1      (src1),
    .A_div_src2      (src2),
    .A_div_busy      (busy),
    .A_div_done      (done),
    .A_div_quotient  (quot),
    .A_div_remainder (remd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on every done pulse.
  always @(negedge clk) begin
    if (reset_n && done) begin
      done_seen++;
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: done seen in cycle %0d with nothing outstanding", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("quotient", quot, e.q);
        check("remainder", remd, e.r);
        check("done_cycle", 32'(cyc), 32'(e.done_cyc));
      end
    end
  end

  // Called right after a negedge; leaves start low one negedge later.
  task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eq, input logic [31:0] er);
    exp_t e;
    int   lat;
    lat = 34;
`ifdef CPU_NIOS_DIV_ZERO_FASTPATH_EN
    if (b == 32'h0) lat = 2;
`endif
    e.q = eq;
    e.r = er;
    e.done_cyc = cyc + lat;
    sb.push_back(e);
    start = 1'b1;
    sgn   = s;
    src1  = a;
    src2  = b;
    @(negedge clk);
    start = 1'b0;
    sgn   = ~s;
    src1  = $urandom;
    src2  = $urandom;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 200; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: %0d result(s) still outstanding", name, sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic run_op(input string name, input logic s, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eq, input logic [31:0] er);
    issue(s, a, b, eq, er);
    wait_drain(name);
  endtask

  initial begin
    int n;
    int seen0;
    checks    = 0;
    failures  = 0;
    done_seen = 0;
    reset_n   = 1'b0;
    start     = 1'b0;
    sgn       = 1'b0;
    src1      = '0;
    src2      = '0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_quotient", quot, 32'd0);
    check("reset_remainder", remd, 32'd0);

    // Unsigned 100/7 with busy window timing.
    n = cyc;
    issue(1'b0, 32'd100, 32'd7, 32'd14, 32'd2);
    check("busy_cycle1", {31'd0, busy}, 32'd1);
    while (cyc < n + 33) @(negedge clk);
    check("busy_cycle33", {31'd0, busy}, 32'd1);
    check("done_low_cycle33", {31'd0, done}, 32'd0);
    @(negedge clk);
    check("busy_low_cycle34", {31'd0, busy}, 32'd0);
    wait_drain("udiv_100_7");

    run_op("sdiv_m100_7",  1'b1, 32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFF2, 32'hFFFF_FFFE);
    run_op("sdiv_100_m7",  1'b1, 32'd100,       32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'd2);
    run_op("sdiv_m100_m7", 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14,        32'hFFFF_FFFE);
    run_op("sdiv_by_zero", 1'b1, 32'h0000_1234, 32'd0,         32'hFFFF_FFFF, 32'h0000_1234);
    run_op("udiv_by_zero", 1'b0, 32'h0000_1234, 32'd0,         32'hFFFF_FFFF, 32'h0000_1234);
    run_op("sdiv_overflow",1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);
    run_op("udiv_big",     1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000);
    run_op("udiv_top_dvs", 1'b0, 32'hFFFF_FFFF, 32'h8000_0001, 32'd1,         32'h7FFF_FFFE);

    // Start mid-operation is ignored; start in the done cycle is accepted.
    n = cyc;
    issue(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    while (cyc < n + 10) @(negedge clk);
    start = 1'b1;
    sgn   = 1'b0;
    src1  = 32'd1000;
    src2  = 32'd3;
    @(negedge clk);
    start = 1'b0;
    while (cyc < n + 34) @(negedge clk);
    issue(1'b0, 32'd1000, 32'd3, 32'd333, 32'd1);
    wait_drain("back_to_back");

    // Asynchronous reset mid-operation.
    n = cyc;
    issue(1'b0, 32'd50, 32'd5, 32'd10, 32'd0);
    while (cyc < n + 12) @(negedge clk);
    reset_n = 1'b0;
    #1;
    sb.delete();
    check("midreset_busy", {31'd0, busy}, 32'd0);
    check("midreset_done", {31'd0, done}, 32'd0);
    check("midreset_quotient", quot, 32'd0);
    check("midreset_remainder", remd, 32'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    seen0 = done_seen;
    repeat (50) @(negedge clk);
    check("no_done_after_reset", 32'(done_seen), 32'(seen0));
    check("idle_after_reset", {31'd0, busy}, 32'd0);

    run_op("udiv_after_reset", 1'b0, 32'd1000, 32'd7, 32'd142, 32'd6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
`default_nettype wire
